// File: rtl/freq_meter.sv
// Measures period and high time of a slow periodic input in clk cycles, with lock and timeout flags.
// Optional FREQ_METER_SYNC_EN adds a two-flop input synchronizer ahead of edge detection.
module freq_meter #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned   MATCH_W  = 4;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
    localparam logic [MATCH_W-1:0] LOCK_THR  = MATCH_W'(LOCK_N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_TIMEOUT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;
    logic               sig_d_q;
    logic               sig_s;
    logic               rise;
    logic [MATCH_W-1:0] match_inc;

`ifdef FREQ_METER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = sig_in;
`endif

    assign rise      = sig_s & ~sig_d_q;
    assign match_inc = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MATCH_W'(1);

    // Next-state and counter logic; en low overrides everything and clears the run state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        match_d   = match_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hcnt_d    = '0;
            match_d   = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    match_d   = '0;
                    locked_d  = 1'b0;
                    timeout_d = 1'b0;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = ST_MEASURE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        state_d   = ST_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        hcnt_d   = CNT_ONE;
                        match_d  = ((cnt_q == period_q) && (match_q != '0)) ? match_inc
                                                                            : MATCH_W'(1);
                        locked_d = (match_d >= LOCK_THR);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        state_d   = ST_TIMEOUT;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + CNT_W'(sig_s);
                    end
                end
                ST_TIMEOUT: begin
                    if (rise) begin
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                        hcnt_d    = CNT_ONE;
                        state_d   = ST_MEASURE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            sig_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            sig_d_q   <= sig_s;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter comparing every cycle against an event-based reference model.
module tb_freq_meter;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LOCK_N = 4;
    localparam int          MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    freq_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: time-stamps of rises and a list of reports since the last clear.
    int m_period, m_high, m_mv, m_locked, m_timeout;
    int m_active, m_last_rise, m_arm_t, m_hc, t;
    int m_s, m_prev, m_sh1, m_sh2, m_el, m_r;
    int q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_period = 0; m_high = 0; m_mv = 0; m_locked = 0; m_timeout = 0;
            m_active = 0; m_last_rise = -1; m_arm_t = 0; m_hc = 0; t = 0;
            m_prev = 0; m_sh1 = 0; m_sh2 = 0;
            q.delete();
        end else begin
`ifdef FREQ_METER_SYNC_EN
            m_s   = m_sh2;
            m_sh2 = m_sh1;
            m_sh1 = int'(sig_in);
`else
            m_s = int'(sig_in);
`endif
            m_r    = (m_s == 1 && m_prev == 0) ? 1 : 0;
            m_prev = m_s;
            m_mv   = 0;
            if (!en) begin
                m_active = 0; m_last_rise = -1; m_timeout = 0; m_locked = 0;
                q.delete();
            end else if (m_active == 0) begin
                m_active = 1; m_arm_t = t; m_last_rise = -1;
            end else begin
                m_el = (m_last_rise >= 0) ? t - m_last_rise : t - m_arm_t - 1;
                if (m_r == 1) begin
                    if (m_last_rise >= 0 && m_timeout == 0) begin
                        m_period = m_el;
                        m_high   = m_hc;
                        m_mv     = 1;
                        q.push_back(m_el);
                        if (q.size() > LOCK_N) void'(q.pop_front());
                        m_locked = (q.size() == LOCK_N) ? 1 : 0;
                        foreach (q[i]) if (q[i] != m_el) m_locked = 0;
                    end
                    m_timeout   = 0;
                    m_last_rise = t;
                    m_hc        = 1;
                end else if (m_timeout == 0) begin
                    if (m_el >= MAXV) begin
                        m_timeout = 1; m_locked = 0;
                        q.delete();
                    end else begin
                        m_hc += m_s;
                    end
                end
            end
            t++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("period",     32'(period),     m_period);
            chk("high_time",  32'(high_time),  m_high);
            chk("meas_valid", 32'(meas_valid), m_mv);
            chk("locked",     32'(locked),     m_locked);
            chk("timeout",    32'(timeout),    m_timeout);
        end
    end

    task automatic cyc(input logic e, input logic s);
        en     = e;
        sig_in = s;
        @(negedge clk);
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                cyc(1'b1, (i < hi) ? 1'b1 : 1'b0);
    endtask

    initial begin
        int per, hi, n, k;
        rst = 1'b0; en = 1'b0; sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period",  32'(period),     0);
        chk("rst_high",    32'(high_time),  0);
        chk("rst_valid",   32'(meas_valid), 0);
        chk("rst_locked",  32'(locked),     0);
        chk("rst_timeout", 32'(timeout),    0);
        rst = 1'b1;
        chk_on = 1'b1;
        cyc(1'b1, 1'b0);

        wave(2, 1, 8);
        chk("tog_period", 32'(period),    2);
        chk("tog_high",   32'(high_time), 1);
        chk("tog_locked", 32'(locked),    1);

        wave(8, 4, 6);
        chk("div8_period", 32'(period),    8);
        chk("div8_high",   32'(high_time), 4);
        chk("div8_locked", 32'(locked),    1);

        wave(4, 2, 6);
        wave(8, 4, 1);
        repeat (3) cyc(1'b1, 1'b1);
        chk("switch_period", 32'(period), 8);
        chk("switch_locked", 32'(locked), 0);
        repeat (5) cyc(1'b1, 1'b0);
        wave(8, 4, 5);

        repeat (300) cyc(1'b1, 1'b0);
        chk("to_flag",   32'(timeout), 1);
        chk("to_locked", 32'(locked),  0);
        wave(4, 2, 4);
        chk("to_clear",  32'(timeout), 0);
        chk("to_period", 32'(period),  4);

        wave(6, 3, 3);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("idle_locked",  32'(locked),  0);
        chk("idle_timeout", 32'(timeout), 0);
        chk("idle_period",  32'(period),  6);
        cyc(1'b1, 1'b0);
        wave(6, 3, 3);

        for (int seg = 0; seg < 40; seg++) begin
            k = $urandom_range(9, 0);
            if (k == 0) begin
                n = $urandom_range(5, 1);
                repeat (n) cyc(1'b0, 1'($urandom_range(1, 0)));
            end else if (k == 1) begin
                repeat (260) cyc(1'b1, 1'b0);
            end else if (k == 2) begin
                repeat (20) cyc(1'($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)));
            end else begin
                per = $urandom_range(24, 2);
                hi  = $urandom_range(per - 1, 1);
                n   = $urandom_range(6, 1);
                wave(per, hi, n);
            end
        end

        wave(5, 2, 2);
        cyc(1'b1, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_period",  32'(period),     0);
        chk("mid_rst_high",    32'(high_time),  0);
        chk("mid_rst_valid",   32'(meas_valid), 0);
        chk("mid_rst_locked",  32'(locked),     0);
        chk("mid_rst_timeout", 32'(timeout),    0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        wave(5, 2, 5);
        chk("post_rst_period", 32'(period),    5);
        chk("post_rst_high",   32'(high_time), 2);
        chk("post_rst_locked", 32'(locked),    1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
